// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared types and constants for the two-port I2C command arbiter.
// Holds FSM encodings, port count, field widths and default timing parameters.
package i2c_cmd_arbiter_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int TYPE_W     = 8;
  localparam int LEN_W      = 16;
  localparam int DATA_W     = 8;
  localparam int IDX_W      = 16;
  localparam int SRC_W      = 8;
  localparam int WAIT_CNT_W = 22;

  localparam int DEF_TIMEOUT_CYCLES = 2500000;
  localparam int DEF_SETTLE_CYCLES  = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_SETTLE = 2'd2,
    ARB_WAIT   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [TYPE_W-1:0] cmd_type;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  data_index;
    logic              start;
    logic              data_valid;
    logic              done;
  } cmd_t;

  function automatic logic port_of(input logic [NUM_PORTS-1:0] onehot);
    return (onehot == 2'b10);
  endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// Requester, handler and status signals of the command arbiter.
// master = arbiter side, slave = requesters plus handler.
interface i2c_cmd_arbiter_if;
  import i2c_cmd_arbiter_pkg::*;

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS*TYPE_W-1:0] rq_cmd_type;
  logic [NUM_PORTS*LEN_W-1:0]  rq_cmd_length;
  logic [NUM_PORTS*DATA_W-1:0] rq_cmd_data;
  logic [NUM_PORTS*IDX_W-1:0]  rq_cmd_data_index;
  logic [NUM_PORTS-1:0]        rq_cmd_start;
  logic [NUM_PORTS-1:0]        rq_cmd_data_valid;
  logic [NUM_PORTS-1:0]        rq_cmd_done;
  logic [NUM_PORTS-1:0]        rq_cmd_ready;

  logic [TYPE_W-1:0] cmd_type;
  logic [LEN_W-1:0]  cmd_length;
  logic [DATA_W-1:0] cmd_data;
  logic [IDX_W-1:0]  cmd_data_index;
  logic              cmd_start;
  logic              cmd_data_valid;
  logic              cmd_done;
  logic              cmd_ready;

  logic              upload_active;
  logic              upload_req;
  logic [DATA_W-1:0] upload_data;
  logic [SRC_W-1:0]  upload_source;
  logic              upload_valid;
  logic              upload_ready;

  logic [NUM_PORTS-1:0]        rq_upload_req;
  logic [NUM_PORTS-1:0]        rq_upload_valid;
  logic [NUM_PORTS*DATA_W-1:0] rq_upload_data;
  logic [NUM_PORTS*SRC_W-1:0]  rq_upload_source;
  logic [NUM_PORTS-1:0]        rq_upload_ready;

  logic busy;
  logic owner;
  logic timeout_pulse;

  modport master (
    input  req, rq_cmd_type, rq_cmd_length, rq_cmd_data, rq_cmd_data_index,
           rq_cmd_start, rq_cmd_data_valid, rq_cmd_done, cmd_ready,
           upload_active, upload_req, upload_data, upload_source, upload_valid,
           rq_upload_ready,
    output gnt, rq_cmd_ready, cmd_type, cmd_length, cmd_data, cmd_data_index,
           cmd_start, cmd_data_valid, cmd_done, upload_ready,
           rq_upload_req, rq_upload_valid, rq_upload_data, rq_upload_source,
           busy, owner, timeout_pulse
  );

  modport slave (
    output req, rq_cmd_type, rq_cmd_length, rq_cmd_data, rq_cmd_data_index,
           rq_cmd_start, rq_cmd_data_valid, rq_cmd_done, cmd_ready,
           upload_active, upload_req, upload_data, upload_source, upload_valid,
           rq_upload_ready,
    input  gnt, rq_cmd_ready, cmd_type, cmd_length, cmd_data, cmd_data_index,
           cmd_start, cmd_data_valid, cmd_done, upload_ready,
           rq_upload_req, rq_upload_valid, rq_upload_data, rq_upload_source,
           busy, owner, timeout_pulse
  );

endinterface

// File: rtl/i2c_rr_arb2.sv
// Two-input round-robin picker: one-hot pick, preferring the port that did not win last.
// Purely combinational, no backpressure of its own.
module i2c_rr_arb2
  import i2c_cmd_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] pick
);

  always_comb begin
    pick = '0;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Arbitrates two command requesters onto one I2C handler; grant appears the cycle after the pick,
// the cmd path is a zero-latency mux, and cmd_ready/upload_ready pass straight through to the owner.
module i2c_cmd_arbiter
  import i2c_cmd_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
  input logic              clk,
  input logic              rst_n,
  i2c_cmd_arbiter_if.master bus
);

  localparam logic [WAIT_CNT_W-1:0] TMO_LAST    = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] SETTLE_LAST = WAIT_CNT_W'(SETTLE_CYCLES - 1);

  arb_state_t            state_q, state_nxt;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_nxt, pick;
  logic                  owner_q, owner_nxt;
  logic                  started_q, started_nxt;
  logic                  tmo_q, tmo_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_nxt;
  logic                  release_ok;
  cmd_t                  port_cmd [NUM_PORTS];
  cmd_t                  fwd;

  i2c_rr_arb2 u_rr (
    .req  (bus.req),
    .last (owner_q),
    .pick (pick)
  );

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_cmd[p].cmd_type   = bus.rq_cmd_type[p*TYPE_W +: TYPE_W];
    assign port_cmd[p].length     = bus.rq_cmd_length[p*LEN_W +: LEN_W];
    assign port_cmd[p].data       = bus.rq_cmd_data[p*DATA_W +: DATA_W];
    assign port_cmd[p].data_index = bus.rq_cmd_data_index[p*IDX_W +: IDX_W];
    assign port_cmd[p].start      = bus.rq_cmd_start[p];
    assign port_cmd[p].data_valid = bus.rq_cmd_data_valid[p];
    assign port_cmd[p].done       = bus.rq_cmd_done[p];

    // Upload path only reaches the owner; everyone else sees zeros.
    assign bus.rq_upload_data[p*DATA_W +: DATA_W]  = gnt_q[p] ? bus.upload_data   : '0;
    assign bus.rq_upload_source[p*SRC_W +: SRC_W]  = gnt_q[p] ? bus.upload_source : '0;
  end

  // gnt_q is one-hot and always matches owner_q while nonzero.
  assign fwd = (gnt_q != '0) ? port_cmd[owner_q] : '0;

  assign bus.gnt            = gnt_q;
  assign bus.cmd_type       = fwd.cmd_type;
  assign bus.cmd_length     = fwd.length;
  assign bus.cmd_data       = fwd.data;
  assign bus.cmd_data_index = fwd.data_index;
  assign bus.cmd_start      = fwd.start;
  assign bus.cmd_data_valid = fwd.data_valid;
  assign bus.cmd_done       = fwd.done;
  assign bus.rq_cmd_ready   = gnt_q & {NUM_PORTS{bus.cmd_ready}};

  assign bus.rq_upload_req   = gnt_q & {NUM_PORTS{bus.upload_req}};
  assign bus.rq_upload_valid = gnt_q & {NUM_PORTS{bus.upload_valid}};
  assign bus.upload_ready    = |(gnt_q & bus.rq_upload_ready);

  assign bus.busy          = (state_q != ARB_IDLE);
  assign bus.owner         = owner_q;
  assign bus.timeout_pulse = tmo_q;

  assign release_ok = bus.cmd_ready & ~bus.upload_active & ~bus.upload_req;

  always_comb begin
    state_nxt    = state_q;
    gnt_nxt      = gnt_q;
    owner_nxt    = owner_q;
    started_nxt  = started_q;
    wait_cnt_nxt = wait_cnt_q;
    tmo_nxt      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if ((bus.req != '0) && bus.cmd_ready && !bus.upload_active) begin
          gnt_nxt     = pick;
          owner_nxt   = port_of(pick);
          started_nxt = 1'b0;
          state_nxt   = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (fwd.done) begin
          state_nxt    = ARB_SETTLE;
          wait_cnt_nxt = '0;
        end else if (fwd.start) begin
          started_nxt = 1'b1;
        end else if (!started_q && !bus.req[owner_q]) begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = '0;
        end
      end
      ARB_SETTLE, ARB_WAIT: begin
        // One counter spans settle and wait so the timeout bounds both.
        wait_cnt_nxt = wait_cnt_q + WAIT_CNT_W'(1);
        if ((state_q == ARB_WAIT) && release_ok) begin
          state_nxt    = ARB_IDLE;
          gnt_nxt      = '0;
          started_nxt  = 1'b0;
          wait_cnt_nxt = '0;
        end else if (wait_cnt_q == TMO_LAST) begin
          state_nxt    = ARB_IDLE;
          gnt_nxt      = '0;
          started_nxt  = 1'b0;
          wait_cnt_nxt = '0;
          tmo_nxt      = 1'b1;
        end else if ((state_q == ARB_SETTLE) && (wait_cnt_q == SETTLE_LAST)) begin
          state_nxt = ARB_WAIT;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      owner_q    <= 1'b1;
      started_q  <= 1'b0;
      tmo_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_nxt;
      gnt_q      <= gnt_nxt;
      owner_q    <= owner_nxt;
      started_q  <= started_nxt;
      tmo_q      <= tmo_nxt;
      wait_cnt_q <= wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: a vector table for one full port-0 command,
// then hand sequences for reset, alternation, uploads, timeout and early request drop.
module tb_i2c_cmd_arbiter;
  import i2c_cmd_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_cmd_arbiter_if bus ();

  i2c_cmd_arbiter #(
    .TIMEOUT_CYCLES (100),
    .SETTLE_CYCLES  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  req, start, dval, done;
    logic [15:0] data;
    logic        cready;
    logic [1:0]  e_gnt;
    logic        e_busy;
    logic [7:0]  e_type, e_data;
    logic [2:0]  e_strb;
    logic [1:0]  e_rdy;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input string nm, input logic [1:0] exp);
    int n = 0;
    while (bus.gnt == 2'b00 && n < 20) begin
      cyc();
      n++;
    end
    chk(nm, bus.gnt, exp);
  endtask

  task automatic wait_rel(input string nm);
    int n = 0;
    while (bus.gnt != 2'b00 && n < 150) begin
      cyc();
      n++;
    end
    chk(nm, {bus.gnt, bus.busy}, 3'b000);
  endtask

  task automatic txn(input int p);
    bus.rq_cmd_start[p] = 1'b1;
    cyc();
    bus.rq_cmd_start[p] = 1'b0;
    bus.rq_cmd_done[p]  = 1'b1;
    cyc();
    bus.rq_cmd_done[p]  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] alt_exp [4];
    logic [7:0] d;
    int first;
    int width;
    logic [1:0] gnt_at_pulse;

    // name, req, start, dval, done, data, cready | gnt, busy, type, data, {start,dval,done}, rdy
    vecs[0]  = '{"idle_req",    2'b01, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 3'b000, 2'b00};
    vecs[1]  = '{"grant_start", 2'b01, 2'b01, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b01, 1'b1, 8'h04, 8'h00, 3'b100, 2'b01};
    vecs[2]  = '{"byte0",       2'b01, 2'b00, 2'b11, 2'b00, 16'h55A1, 1'b1, 2'b01, 1'b1, 8'h04, 8'hA1, 3'b010, 2'b01};
    vecs[3]  = '{"byte1_nrdy",  2'b01, 2'b00, 2'b01, 2'b00, 16'h00A2, 1'b0, 2'b01, 1'b1, 8'h04, 8'hA2, 3'b010, 2'b00};
    vecs[4]  = '{"byte2_reqlo", 2'b00, 2'b00, 2'b01, 2'b00, 16'h00A3, 1'b1, 2'b01, 1'b1, 8'h04, 8'hA3, 3'b010, 2'b01};
    vecs[5]  = '{"done",        2'b00, 2'b00, 2'b00, 2'b01, 16'h0000, 1'b1, 2'b01, 1'b1, 8'h04, 8'h00, 3'b001, 2'b01};
    vecs[6]  = '{"settle0",     2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b01, 1'b1, 8'h04, 8'h00, 3'b000, 2'b01};
    vecs[7]  = '{"settle1",     2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b01, 1'b1, 8'h04, 8'h00, 3'b000, 2'b01};
    vecs[8]  = '{"wait",        2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b01, 1'b1, 8'h04, 8'h00, 3'b000, 2'b01};
    vecs[9]  = '{"released",    2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 3'b000, 2'b00};
    vecs[10] = '{"idle",        2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 3'b000, 2'b00};

    rst_n                 = 1'b0;
    bus.req               = 2'b00;
    bus.rq_cmd_type       = 16'h3304;
    bus.rq_cmd_length     = 32'hBEEF_0003;
    bus.rq_cmd_data       = 16'h0000;
    bus.rq_cmd_data_index = 32'h0000_0000;
    bus.rq_cmd_start      = 2'b00;
    bus.rq_cmd_data_valid = 2'b00;
    bus.rq_cmd_done       = 2'b00;
    bus.cmd_ready         = 1'b1;
    bus.upload_active     = 1'b0;
    bus.upload_req        = 1'b0;
    bus.upload_data       = 8'h00;
    bus.upload_source     = 8'h00;
    bus.upload_valid      = 1'b0;
    bus.rq_upload_ready   = 2'b00;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_gnt",   bus.gnt, 2'b00);
    chk("reset_busy",  bus.busy, 1'b0);
    chk("reset_owner", bus.owner, 1'b1);
    chk("reset_tmo",   bus.timeout_pulse, 1'b0);
    chk("reset_strb",  {bus.cmd_start, bus.cmd_data_valid, bus.cmd_done}, 3'b000);
    chk("reset_type",  bus.cmd_type, 8'h00);
    rst_n = 1'b1;

    // Full port-0 command, one vector per clock.
    for (int i = 0; i < NV; i++) begin
      bus.req               = vecs[i].req;
      bus.rq_cmd_start      = vecs[i].start;
      bus.rq_cmd_data_valid = vecs[i].dval;
      bus.rq_cmd_done       = vecs[i].done;
      bus.rq_cmd_data       = vecs[i].data;
      bus.cmd_ready         = vecs[i].cready;
      #1;
      chk({vecs[i].name, "_gnt"},  bus.gnt, vecs[i].e_gnt);
      chk({vecs[i].name, "_busy"}, bus.busy, vecs[i].e_busy);
      chk({vecs[i].name, "_type"}, bus.cmd_type, vecs[i].e_type);
      chk({vecs[i].name, "_data"}, bus.cmd_data, vecs[i].e_data);
      chk({vecs[i].name, "_strb"}, {bus.cmd_start, bus.cmd_data_valid, bus.cmd_done}, vecs[i].e_strb);
      chk({vecs[i].name, "_rdy"},  bus.rq_cmd_ready, vecs[i].e_rdy);
      @(posedge clk);
      #2;
    end

    // Asynchronous reset while port 1 sits in ARB_WAIT.
    bus.req = 2'b10;
    wait_gnt("rst_gnt1", 2'b10);
    bus.rq_cmd_start[1] = 1'b1;
    cyc();
    bus.rq_cmd_start[1] = 1'b0;
    bus.rq_cmd_done[1]  = 1'b1;
    bus.cmd_ready       = 1'b0;
    cyc();
    bus.rq_cmd_done[1]  = 1'b0;
    bus.req             = 2'b00;
    repeat (3) cyc();
    bus.rq_cmd_start      = 2'b10;
    bus.rq_cmd_data_valid = 2'b10;
    #1;
    chk("rst_pre_strb", {bus.cmd_start, bus.cmd_data_valid}, 2'b11);
    chk("rst_pre_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_gnt",  bus.gnt, 2'b00);
    chk("rst_async_busy", bus.busy, 1'b0);
    chk("rst_async_strb", {bus.cmd_start, bus.cmd_data_valid, bus.cmd_done}, 3'b000);
    chk("rst_async_rdy",  bus.rq_cmd_ready, 2'b00);
    bus.rq_cmd_start      = 2'b00;
    bus.rq_cmd_data_valid = 2'b00;
    bus.cmd_ready         = 1'b1;
    cyc();
    rst_n = 1'b1;

    // Both ports contending: port 0 first after reset, then strict alternation.
    alt_exp[0] = 2'b01;
    alt_exp[1] = 2'b10;
    alt_exp[2] = 2'b01;
    alt_exp[3] = 2'b10;
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_gnt($sformatf("alt%0d_gnt", i), alt_exp[i]);
      txn((alt_exp[i] == 2'b01) ? 0 : 1);
      wait_rel($sformatf("alt%0d_release", i));
    end
    bus.req = 2'b00;

    // Port 1 read with four uploads routed only to it.
    bus.req = 2'b10;
    wait_gnt("up_gnt", 2'b10);
    bus.upload_active   = 1'b1;
    bus.rq_cmd_start[1] = 1'b1;
    cyc();
    bus.rq_cmd_start[1] = 1'b0;
    bus.req             = 2'b00;
    bus.rq_cmd_done[1]  = 1'b1;
    cyc();
    bus.rq_cmd_done[1]  = 1'b0;
    bus.rq_upload_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      d = 8'h10 + 8'(i);
      bus.upload_req    = 1'b1;
      bus.upload_valid  = 1'b1;
      bus.upload_source = 8'h06;
      bus.upload_data   = d;
      #1;
      chk($sformatf("up%0d_reqvld", i), {bus.rq_upload_req, bus.rq_upload_valid}, 4'b1010);
      chk($sformatf("up%0d_data", i),   bus.rq_upload_data, {d, 8'h00});
      chk($sformatf("up%0d_src", i),    bus.rq_upload_source, 16'h0600);
      chk($sformatf("up%0d_ready", i),  bus.upload_ready, 1'b1);
      cyc();
    end
    bus.upload_req   = 1'b0;
    bus.upload_valid = 1'b0;
    repeat (5) cyc();
    chk("up_hold_gnt", bus.gnt, 2'b10);
    bus.upload_active = 1'b0;
    wait_rel("up_release");
    bus.rq_upload_ready = 2'b00;

    // Handler never ready again: forced release 100 cycles after settle starts.
    bus.req = 2'b01;
    wait_gnt("tmo_gnt", 2'b01);
    bus.rq_cmd_start[0] = 1'b1;
    cyc();
    bus.rq_cmd_start[0] = 1'b0;
    bus.rq_cmd_done[0]  = 1'b1;
    cyc();
    bus.rq_cmd_done[0]  = 1'b0;
    bus.cmd_ready       = 1'b0;
    first = -1;
    width = 0;
    gnt_at_pulse = 2'b11;
    for (int k = 1; k <= 105; k++) begin
      cyc();
      if (bus.timeout_pulse) begin
        width++;
        if (first < 0) begin
          first = k;
          gnt_at_pulse = bus.gnt;
        end
      end
    end
    chk("tmo_cycle",     first, 100);
    chk("tmo_width",     width, 1);
    chk("tmo_gnt_clear", gnt_at_pulse, 2'b00);
    chk("tmo_idle_busy", bus.busy, 1'b0);
    bus.cmd_ready = 1'b1;
    wait_gnt("tmo_regrant", 2'b01);

    // Port 0 holds grant without starting, then drops req while port 1 waits.
    bus.req = 2'b11;
    bus.rq_cmd_data_valid = 2'b10;
    #1;
    chk("abort_no_strb", {bus.cmd_start, bus.cmd_data_valid, bus.cmd_done}, 3'b000);
    cyc();
    chk("abort_hold_gnt", bus.gnt, 2'b01);
    bus.req = 2'b10;
    cyc();
    chk("abort_idle", {bus.gnt, bus.busy}, 3'b000);
    cyc();
    chk("abort_regrant", bus.gnt, 2'b10);
    chk("abort_owner",   bus.owner, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2500000, max ARB_WAIT cycles (50 ms at 50 MHz) before forced release.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, cycles waited after forwarded cmd_done before completion sampling.
REQ-003 SHALL have clk  input  1  system clock, 50 MHz; rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req  input  2  per-port level request, held until grant; gnt  output  2  one-hot grant, registered.
REQ-005 SHALL have packed requester cmd inputs, port p at slice [p*W +: W]: rq_cmd_type 16, rq_cmd_length 32, rq_cmd_data 16, rq_cmd_data_index 32, rq_cmd_start 2, rq_cmd_data_valid 2, rq_cmd_done 2.
REQ-006 SHALL have rq_cmd_ready  output  2  per-port ready.
REQ-007 SHALL have handler-side outputs cmd_type 8, cmd_length 16, cmd_data 8, cmd_data_index 16, cmd_start 1, cmd_data_valid 1, cmd_done 1; input cmd_ready 1.
REQ-008 SHALL have handler upload inputs upload_active 1, upload_req 1, upload_data 8, upload_source 8, upload_valid 1; output upload_ready 1.
REQ-009 SHALL have per-port upload outputs rq_upload_req 2, rq_upload_valid 2, rq_upload_data 16, rq_upload_source 16; input rq_upload_ready 2.
REQ-010 SHALL have busy  output  1  transaction owned; owner  output  1  last/current granted port; timeout_pulse  output  1  one-cycle forced-release flag.

Function
REQ-011 SHALL implement states ARB_IDLE, ARB_GRANT, ARB_SETTLE, ARB_WAIT.
REQ-012 ARB_IDLE: if any req and cmd_ready=1 and upload_active=0, SHALL grant one port, set gnt next cycle, go ARB_GRANT.
REQ-013 Both requesting SHALL grant port != owner (round-robin); single requester SHALL be granted directly; owner updates on grant.
REQ-014 ARB_GRANT: SHALL combinationally forward granted port cmd_* to handler and cmd_ready back to that port (zero latency).
REQ-015 ARB_GRANT: req drop before any forwarded cmd_start SHALL return to ARB_IDLE next cycle, gnt cleared.
REQ-016 After cmd_start is forwarded, req SHALL be ignored until release.
REQ-017 Forwarded cmd_done SHALL move to ARB_SETTLE; SETTLE_CYCLES later go ARB_WAIT.
REQ-018 ARB_WAIT: cmd_ready=1, upload_active=0, upload_req=0 in one cycle SHALL release: gnt=0, ARB_IDLE.
REQ-019 Non-granted ports: rq_cmd_ready=0, rq_upload_req=0, rq_upload_valid=0; no grant: handler cmd_start/cmd_data_valid/cmd_done=0, other cmd_* 0.
REQ-020 Handler upload_req/valid/data/source SHALL route only to owner while gnt nonzero; upload_ready = owner's rq_upload_ready, else 0.
REQ-021 16-bit wait counter SHALL cover ARB_SETTLE+ARB_WAIT; reaching TIMEOUT_CYCLES-1 SHALL force release and pulse timeout_pulse once.
REQ-022 busy SHALL be 1 in every state except ARB_IDLE.
REQ-023 A grant SHALL NOT be issued in the release cycle; earliest regrant is one cycle after ARB_IDLE entry.

Reset
REQ-024 Reset SHALL give ARB_IDLE, gnt=0, owner=1 (port 0 wins first contention), busy=0, timeout_pulse=0, counters 0, all handler strobes 0.
REQ-025 Reset mid-transaction SHALL drop grant and strobes immediately (asynchronous); no partial command is replayed.

Structure
REQ-026 Shared package SHALL hold state encodings, port count (2), field widths, default TIMEOUT_CYCLES/SETTLE_CYCLES.
REQ-027 SHALL contain one sub-module, i2c_rr_arb2: 2-input round-robin picker (req, last owner -> one-hot pick).
REQ-028 Wait counter SHALL be 22 bits to hold 2500000 (overrides REQ-021 width).

Verification
REQ-029 Port0 req, type 0x04, 3 data bytes, done -> gnt=01 two cycles later, bytes pass unchanged, release ~2 cycles after done, busy=0.
REQ-030 Both req in same idle cycle after reset -> gnt=01; next with both -> gnt=10; alternation holds over 4 transactions.
REQ-031 Port1 type 0x06 read len 4 -> 4 uploads reach rq_upload_*[1] only with source 0x06; port0 sees no valid; release after upload_active falls.
REQ-032 Handler holds cmd_ready=0 (TIMEOUT_CYCLES=100 bench) -> timeout_pulse at cycle 100 after settle start, gnt=0, port0 then granted.
REQ-033 Port0 granted, req drops before cmd_start -> ARB_IDLE next cycle, no handler strobes, waiting port1 granted.
REQ-034 rst_n low during ARB_WAIT -> gnt=0, busy=0, cmd_* strobes 0 same cycle; after release, first contention goes to port 0.
